// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: stereo sample buffer between the synthesis core and the I2S
// transmitter. Pairs are pushed over valid/ready and popped once per LRCLK rising
// edge; popped pairs are held on the outputs, and an empty pop raises a one-cycle
// underrun pulse while the last good pair is repeated.
// Optional: define AUDIO_FIFO_STATS_EN to add a saturating underrun_count output.
module audio_sample_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_left,
  input  logic [WIDTH-1:0]         in_right,
  input  logic                     lrclk,
  output logic [WIDTH-1:0]         out_left,
  output logic [WIDTH-1:0]         out_right,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun
`ifdef AUDIO_FIFO_STATS_EN
  ,
  output logic [15:0]              underrun_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [2*WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] out_left_q, out_left_d;
  logic [WIDTH-1:0] out_right_q, out_right_d;
  logic             underrun_q, underrun_d;

  logic push, frame, empty, pop;

  // Handshake and frame-edge decode from registered state only.
  always_comb begin
    in_ready = (level_q != LW'(DEPTH));
    push     = in_valid && in_ready;
    frame    = s2_q && !s3_q;
    empty    = (level_q == '0);
    // A pop only succeeds on stored data; a same-cycle push is not bypassed.
    pop      = frame && !empty;
  end

  // Next-state for pointers, occupancy, held outputs and underrun pulse.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    underrun_d  = frame && empty;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d                  = rd_ptr_q + 1'b1;
      {out_left_d, out_right_d} = mem_q[rd_ptr_q];
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Control state, LRCLK synchronizer and output holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      s1_q        <= lrclk;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      underrun_q  <= underrun_d;
    end
  end

  // Sample storage; no reset since entries are always written before being read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_left, in_right};
    end
  end

  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign level     = level_q;
  assign underrun  = underrun_q;

`ifdef AUDIO_FIFO_STATS_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating count of underrun events, advanced alongside the pulse itself.
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Scoreboard bench for audio_sample_fifo: a queue-based reference model predicts
// pops/underruns per LRCLK rise; a negedge monitor compares the DUT against it.
module tb_audio_sample_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 24;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_left = '0;
  logic [WIDTH-1:0] in_right = '0;
  logic             lrclk = 1'b0;
  logic [WIDTH-1:0] out_left;
  logic [WIDTH-1:0] out_right;
  logic [4:0]       level;
  logic             underrun;
`ifdef AUDIO_FIFO_STATS_EN
  logic [15:0]      underrun_count;
`endif

  audio_sample_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_left       (in_left),
    .in_right      (in_right),
    .lrclk         (lrclk),
    .out_left      (out_left),
    .out_right     (out_right),
    .level         (level),
    .underrun      (underrun)
`ifdef AUDIO_FIFO_STATS_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pairs, held output values, pending-pop timer.
  typedef struct {
    bit               und;
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] r;
  } ev_t;

  logic [2*WIDTH-1:0] mq[$];
  ev_t                exp_q[$];
  logic [WIDTH-1:0]   m_l = '0;
  logic [WIDTH-1:0]   m_r = '0;
  int                 due = 0;
  bit                 lr_prev = 1'b0;
  int                 m_ucnt = 0;
  int                 pre_sz = 0;

  // A rise seen at edge E0 pops at edge E0+2; pop sees state before any same-edge push.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      m_l = '0;
      m_r = '0;
      due = 0;
      lr_prev = 1'b0;
      m_ucnt = 0;
    end else begin
      pre_sz = mq.size();
      if (due > 0) begin
        due--;
        if (due == 0) begin
          if (pre_sz > 0) begin
            {m_l, m_r} = mq.pop_front();
            exp_q.push_back('{1'b0, m_l, m_r});
          end else begin
            if (m_ucnt < 65535) m_ucnt++;
            exp_q.push_back('{1'b1, m_l, m_r});
          end
        end
      end
      if (in_valid && pre_sz < DEPTH) mq.push_back({in_left, in_right});
      if (lrclk && !lr_prev) due = 2;
      lr_prev = lrclk;
    end
  end

  // Monitor: every cycle compare occupancy/ready; consume predicted frame events.
  ev_t ev;
  always @(negedge clk) begin
    check("level", 32'(level), 32'(mq.size()));
    check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    if (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      check("frame_underrun", 32'(underrun), 32'(ev.und));
      check("frame_out_left", 32'(out_left), 32'(ev.l));
      check("frame_out_right", 32'(out_right), 32'(ev.r));
    end else begin
      check("idle_underrun", 32'(underrun), 32'd0);
      check("idle_out_left", 32'(out_left), 32'(m_l));
      check("idle_out_right", 32'(out_right), 32'(m_r));
    end
`ifdef AUDIO_FIFO_STATS_EN
    check("underrun_count", 32'(underrun_count), 32'(m_ucnt));
`endif
  end

  task automatic push1(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic frame();
    lrclk = 1'b1;
    repeat (4) @(posedge clk);
    #1 lrclk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
    check({tag, "_out_left"}, 32'(out_left), 32'd0);
    check({tag, "_out_right"}, 32'(out_right), 32'd0);
  endtask

  logic [WIDTH-1:0] k;
  bit               acc;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_vals("reset");

    // Ordering: three pairs out in push order.
    push1(24'h000001, 24'hFFFFFF);
    push1(24'h7FFFFF, 24'h800000);
    push1(24'h123456, 24'h654321);
    check("order_level3", 32'(level), 32'd3);
    frame();
    check("order_pop1_l", 32'(out_left), 32'h000001);
    frame();
    check("order_pop2_r", 32'(out_right), 32'h800000);
    frame();
    check("order_pop3_l", 32'(out_left), 32'h123456);

    // Underrun on empty: outputs hold last good pair.
    frame();
    check("underrun_hold_l", 32'(out_left), 32'h123456);
    check("underrun_hold_r", 32'(out_right), 32'h654321);
`ifdef AUDIO_FIFO_STATS_EN
    check("underrun_count_1", 32'(underrun_count), 32'd1);
`endif

    // Full: valid held 20 cycles; data only advances after acceptance.
    k = 24'h000100;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_left  = k;
      in_right = ~k;
      acc = (mq.size() < DEPTH);
      @(posedge clk);
      #1;
      if (acc) k = k + 24'd1;
    end
    in_valid = 1'b0;
    check("full_level", 32'(level), 32'd16);
    check("full_in_ready", 32'(in_ready), 32'd0);
    lrclk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("full_pop_level", 32'(level), 32'd15);
    check("full_pop_in_ready", 32'(in_ready), 32'd1);
    check("full_pop_l", 32'(out_left), 32'h000100);
    @(posedge clk);
    #1 lrclk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    repeat (15) frame();
    check("drained_level", 32'(level), 32'd0);

    // Push lands on the same edge as the pop of an empty FIFO.
    lrclk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push1(24'hABCDEF, 24'h102030);
    check("simul_underrun", 32'(underrun), 32'd1);
    check("simul_level", 32'(level), 32'd1);
    @(posedge clk);
    #1 lrclk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    frame();
    check("simul_next_l", 32'(out_left), 32'hABCDEF);
    check("simul_next_r", 32'(out_right), 32'h102030);

    // Reset mid-stream at level 8.
    for (int i = 0; i < 8; i++) push1(24'($urandom), 24'($urandom));
    check("pre_reset_level", 32'(level), 32'd8);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_vals("midreset");
    push1(24'h0A0A0A, 24'h0B0B0B);
    push1(24'h0C0C0C, 24'h0D0D0D);
    frame();
    check("post_reset_first_l", 32'(out_left), 32'h0A0A0A);
    check("post_reset_first_r", 32'(out_right), 32'h0B0B0B);
    frame();

    // Randomized mix of push bursts and frames.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        frame();
      end else begin
        repeat ($urandom_range(1, 6)) begin
          in_valid = 1'($urandom_range(0, 1));
          in_left  = 24'($urandom);
          in_right = 24'($urandom);
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
      end
    end
    repeat (4) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_fifo.md
# audio_sample_fifo

Stereo sample buffer between the synthesis core's 24-bit left/right outputs and the I2S transmitter's parallel data inputs. It decouples the core's bursty sample production from the codec's fixed frame rate. Samples are pushed through a valid/ready port and popped once per LRCLK frame. Each popped pair is held stable on the outputs for the serializer. Underruns are flagged, and the last good sample is repeated instead of glitching.

## Interface
- `DEPTH`, 16: FIFO entries, one stereo pair each; must be a power of two, 2..256.
- `WIDTH`, 24: sample width per channel.
- `clk` in 1: system clock, 100 MHz domain shared with the I2S transmitter.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: producer offers a pair.
- `in_ready` out 1: FIFO can accept a pair.
- `in_left` in WIDTH: left sample, two's complement.
- `in_right` in WIDTH: right sample, two's complement.
- `lrclk` in 1: frame clock from the I2S transmitter; treated as asynchronous.
- `out_left` out WIDTH: held left sample, feeds the transmitter's left data input.
- `out_right` out WIDTH: held right sample, feeds the transmitter's right data input.
- `level` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `underrun` out 1: one-cycle pulse when a pop finds the FIFO empty.
- `underrun_count` out 16: present only with `AUDIO_FIFO_STATS_EN`.

## Operation
- Storage: DEPTH×(2·WIDTH) register array.
- Pointers: write and read pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Occupancy: a separate `level` counter provides full/empty.
- Push: occurs when `in_valid && in_ready`. It stores `{in_left,in_right}` at the write pointer and increments the write pointer.
- `in_ready` = (`level != DEPTH`). It is combinational from the registered `level`. Data must stay stable while `in_valid` is high and `in_ready` is low.
- Frame detect: `lrclk` passes through a 2-flop synchronizer (s1, s2), then a delay flop s3. `frame = s2 & ~s3`, i.e. one pulse per LRCLK rising edge.
- Pop on `frame`, non-empty case: `out_left`/`out_right` take the head entry and the read pointer increments.
- Pop on `frame`, empty case: outputs hold their previous value and `underrun` pulses for 1 cycle.
- Push and pop in the same cycle: `level` is unchanged. If `level` was 0, there is no bypass: the push is stored, the pop underruns, and `level` becomes 1.
- Push and pop while full: `in_ready` is 0, so there is no push. The pop proceeds and `level` becomes DEPTH-1.
- Outputs change only on a successful pop. Between pops they are stable registers.
- Reset values:
  - pointers, `level`, s1/s2/s3: 0;
  - `out_left`, `out_right`: 0;
  - `underrun`: 0;
  - `in_ready` is therefore 1;
  - `underrun_count`: 0.
- Reset asserted mid-operation clears all state immediately. Array contents are don't-care and are never read before they are rewritten.

## Timing
- `lrclk` rising edge sampled into s1 at edge E0 → `frame` high during the cycle after E1 → pop committed at E2.
- New `out_*` values are visible after E2. Latency is 2 clk edges after first sampling, ≤3 cycles from the async edge.
- Push-to-`level` latency is 1 cycle. Pushes earn `in_ready` deassertion the cycle after `level` reaches DEPTH.
- Throughput: 1 push per cycle; 1 pop per LRCLK period.
- `underrun` is high for exactly the cycle after E2 of the offending frame.

## Configuration
- Macro: `AUDIO_FIFO_STATS_EN`.
- Defined:
  - the `underrun_count` port exists;
  - it increments on each `underrun` pulse and saturates at 16'hFFFF;
  - it is cleared only by reset.
- Undefined: the port and its counter are absent and the remaining behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0, then release. Expect `out_left`=`out_right`=0, `level`=0, `in_ready`=1, `underrun`=0.
- Ordering: push (L,R) = (0x000001,0xFFFFFF), (0x7FFFFF,0x800000), (0x123456,0x654321), then apply 3 `lrclk` rises. Expect the outputs in that order, each appearing 2 edges after sampling, and `level` stepping 3→2→1→0.
- Underrun: with the FIFO empty after the previous case, apply a `lrclk` rise. Expect a 1-cycle `underrun`, outputs held at (0x123456,0x654321), and `underrun_count`=1 with the macro defined.
- Full: hold `in_valid`=1 for 20 cycles with no frames. Expect exactly 16 accepted, `level`=16 and `in_ready`=0. One `lrclk` rise then gives `level`=15 and `in_ready`=1 next cycle.
- Simultaneous at empty: a push coincides with the `frame` cycle. Expect `underrun`=1, `level`=1, and the next frame outputs the pushed pair.
- Reset mid-stream: at `level`=8, pulse `rst_n` low for 1 cycle. Expect all outputs back at their reset values, and the first post-reset push is popped first.
